// File: rtl/bcd_sched_pkg.sv
// bcd_sched_pkg: shared state encoding and constants for the BCD converter scheduler.
package bcd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        WAIT_DONE,
        ABORT,
        NEXT
    } state_e;

    localparam int DIGITS_W        = 16;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/next_channel_finder.sv
// next_channel_finder: picks the lowest enabled channel above ch_i, or the lowest overall when start_i is set.
module next_channel_finder #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] en_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic              start_i,
    output logic [CH_W-1:0]   next_o,
    output logic              found_o
);

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en_i[i] && (start_i || i > int'(ch_i))) begin
                next_o  = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_scheduler.sv
// bcd_scheduler: once per frame, converts every enabled channel's binary value through one
// shared bcd converter and holds the per-channel BCD results for the renderer.
module bcd_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int NUM_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vsync,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*NUM_W-1:0]      numbers,
    output logic                         bcd_load,
    output logic [NUM_W-1:0]             bcd_number,
    input  logic                         bcd_ready,
    input  logic [DIGITS_W-1:0]          bcd_digits,
    output logic [NUM_CH*DIGITS_W-1:0]   digits_out,
    output logic [NUM_CH-1:0]            digits_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    output logic [NUM_CH-1:0]            timeout_err
);

    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW   = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_e                       state_q, state_d;
    logic                         vsync_q;
    logic [NUM_CH-1:0]            en_q, en_d;
    logic [NUM_CH*NUM_W-1:0]      snap_q, snap_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic [NUM_W-1:0]             num_q, num_d;
    logic [NUM_CH*DIGITS_W-1:0]   dig_q, dig_d;
    logic [NUM_CH-1:0]            val_q, val_d;
    logic [NUM_CH-1:0]            terr_q, terr_d;
    logic                         busy_q, done_q, done_d, ovr_q, ovr_d;
    logic                         frame_start, found;
    logic [CH_W-1:0]              nxt;
    logic [NUM_CH*NUM_W-1:0]      src;

    assign frame_start = vsync_q & ~vsync;
    // In IDLE the live inputs are searched so the first LOAD can follow the edge directly.
    assign src = state_q == IDLE ? numbers : snap_q;

    next_channel_finder #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_finder (
        .en_i    (state_q == IDLE ? ch_enable : en_q),
        .ch_i    (ch_q),
        .start_i (state_q == IDLE),
        .next_o  (nxt),
        .found_o (found)
    );

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        snap_d  = snap_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        num_d   = num_q;
        dig_d   = dig_q;
        val_d   = val_q;
        terr_d  = terr_q;
        done_d  = 1'b0;
        ovr_d   = frame_start && state_q != IDLE;
        case (state_q)
            IDLE: if (frame_start) begin
                snap_d = numbers;
                en_d   = ch_enable;
                if (found) begin
                    ch_d    = nxt;
                    num_d   = src[nxt*NUM_W +: NUM_W];
                    state_d = LOAD;
                end else begin
                    done_d = 1'b1;
                end
            end
            LOAD: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (!bcd_ready) begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end else if (timer_q == TMAX) begin
                state_d = ABORT;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            WAIT_DONE: if (bcd_ready) begin
                dig_d[ch_q*DIGITS_W +: DIGITS_W] = bcd_digits;
                val_d[ch_q] = 1'b1;
                state_d     = NEXT;
            end else if (timer_q == TMAX) begin
                state_d = ABORT;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            ABORT: begin
                val_d[ch_q]  = 1'b0;
                terr_d[ch_q] = 1'b1;
                state_d      = NEXT;
            end
            NEXT: if (found) begin
                ch_d    = nxt;
                num_d   = src[nxt*NUM_W +: NUM_W];
                state_d = LOAD;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            en_q    <= '0;
            snap_q  <= '0;
            ch_q    <= '0;
            timer_q <= '0;
            num_q   <= '0;
            dig_q   <= '0;
            val_q   <= '0;
            terr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            en_q    <= en_d;
            snap_q  <= snap_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            num_q   <= num_d;
            dig_q   <= dig_d;
            val_q   <= val_d;
            terr_q  <= terr_d;
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bcd_load     = state_q == LOAD;
    assign bcd_number   = num_q;
    assign digits_out   = dig_q;
    assign digits_valid = val_q;
    assign timeout_err  = terr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_bcd_scheduler.sv
// tb_bcd_scheduler: random frame sweeps against a frame-level reference model and a behavioural bcd converter.
module tb_bcd_scheduler;

    localparam int NUM_CH = 4;
    localparam int NUM_W  = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 vsync = 1'b1;
    logic [NUM_CH-1:0]    ch_enable = '0;
    logic [63:0]          numbers = '0;
    logic                 bcd_load;
    logic [NUM_W-1:0]     bcd_number;
    logic                 bcd_ready = 1'b1;
    logic [15:0]          bcd_digits = '0;
    logic [63:0]          digits_out;
    logic [NUM_CH-1:0]    digits_valid;
    logic                 busy, done, overrun;
    logic [NUM_CH-1:0]    timeout_err;

    int errors = 0;
    int checks = 0;
    int frame_loads = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int stall_abs = -1;
    int cv_cnt = 0;
    logic [15:0] cv_num = '0;
    logic [15:0] loads[$];

    logic [63:0] exp_dig = '0;
    logic [3:0]  exp_val = '0;
    logic [3:0]  exp_terr = '0;

    bcd_scheduler #(.NUM_CH(NUM_CH), .NUM_W(NUM_W), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .ch_enable    (ch_enable),
        .numbers      (numbers),
        .bcd_load     (bcd_load),
        .bcd_number   (bcd_number),
        .bcd_ready    (bcd_ready),
        .bcd_digits   (bcd_digits),
        .digits_out   (digits_out),
        .digits_valid (digits_valid),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [63:0] rand_nums();
        logic [63:0] r;
        for (int c = 0; c < NUM_CH; c++) r[c*16 +: 16] = 16'($urandom_range(0, 9999));
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bcd_load) begin
            loads.push_back(bcd_number);
            frame_loads++;
        end
        if (done) done_cnt++;
        if (overrun) ovr_cnt++;
    end

    // Converter model: ready drops after a load and rises with the result 20 cycles later;
    // the load whose ordinal equals stall_abs is ignored so ready never drops.
    always @(posedge clk) begin
        if (bcd_load && frame_loads - 1 != stall_abs) begin
            cv_num    <= bcd_number;
            cv_cnt    <= 20;
            bcd_ready <= 1'b0;
        end else if (cv_cnt > 1) begin
            cv_cnt <= cv_cnt - 1;
        end else if (cv_cnt == 1) begin
            cv_cnt     <= 0;
            bcd_ready  <= 1'b1;
            bcd_digits <= to_bcd(int'(cv_num));
        end
    end

    task automatic run_frame(input logic [3:0] en, input logic [63:0] nums, input int stall_pos, input bit inject_ovr);
        int l0, q0, d0, o0, k;
        bit seen;
        logic [15:0] exp_q[$];
        numbers   = nums;
        ch_enable = en;
        vsync     = 1'b1;
        repeat (3) @(negedge clk);
        l0 = frame_loads;
        q0 = loads.size();
        d0 = done_cnt;
        o0 = ovr_cnt;
        stall_abs = stall_pos < 0 ? -1 : l0 + stall_pos;
        k = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en[c]) begin
                exp_q.push_back(nums[c*16 +: 16]);
                if (k == stall_pos) begin
                    exp_val[c]  = 1'b0;
                    exp_terr[c] = 1'b1;
                end else begin
                    exp_dig[c*16 +: 16] = to_bcd(int'(nums[c*16 +: 16]));
                    exp_val[c] = 1'b1;
                end
                k++;
            end
        end
        vsync = 1'b0;
        seen  = 1'b0;
        if (en == 4'd0) begin
            @(negedge clk);
            check("done_after_edge", done, 1);
            seen = done;
        end else begin
            repeat (2) @(negedge clk);
            numbers = rand_nums();
            if (inject_ovr) begin
                vsync = 1'b1;
                @(negedge clk);
                vsync = 1'b0;
            end
            for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
                @(negedge clk);
                seen = done;
            end
        end
        @(negedge clk);
        check("done_seen", seen, 1);
        check("done_pulses", done_cnt - d0, 1);
        check("load_count", frame_loads - l0, exp_q.size());
        for (int i = 0; i < exp_q.size() && q0 + i < loads.size(); i++) check("load_value", loads[q0 + i], exp_q[i]);
        check("digits_out", digits_out, exp_dig);
        check("digits_valid", digits_valid, exp_val);
        check("timeout_err", timeout_err, exp_terr);
        check("overrun_pulses", ovr_cnt - o0, inject_ovr ? 1 : 0);
        check("busy_idle", busy, 0);
        stall_abs = -1;
    endtask

    task automatic reset_checks();
        check("rst_digits", digits_out, 0);
        check("rst_valid", digits_valid, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_load", bcd_load, 0);
        check("rst_number", bcd_number, 0);
    endtask

    initial begin
        int nld;
        logic [3:0] en;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_checks();

        run_frame(4'hF, {16'd9999, 16'd0, 16'd42, 16'd1234}, -1, 1'b0);
        run_frame(4'b0101, rand_nums(), -1, 1'b0);
        run_frame(4'b0000, rand_nums(), -1, 1'b0);
        run_frame(4'hF, rand_nums(), -1, 1'b1);
        run_frame(4'hF, rand_nums(), 1, 1'b0);

        numbers   = rand_nums();
        ch_enable = 4'hF;
        vsync     = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        nld   = 0;
        for (int cyc = 0; cyc < 500 && nld < 3; cyc++) begin
            @(negedge clk);
            if (bcd_load) nld++;
        end
        check("third_load_seen", nld, 3);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reset_checks();
        exp_dig  = '0;
        exp_val  = '0;
        exp_terr = '0;
        repeat (30) @(negedge clk);
        run_frame(4'hF, rand_nums(), -1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            en = 4'($urandom_range(0, 15));
            run_frame(en, rand_nums(), int'($urandom_range(0, 4)) - 1, en != 4'd0 && $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_scheduler.md
Name: bcd_scheduler

Overview:
- Time-shares one `bcd` converter between NUM_CH display values (score, counters, debug numbers).
- Once per frame, on the falling edge of `vsync`, it snapshots every enabled channel's binary value.
- It then runs the values through the converter one at a time, using the converter's `load`/`ready` handshake.
- It latches each 4-digit result into a per-channel register that the pixel/text renderer reads for the whole frame.
- Runs on the pixel clock domain, between `VgaSyncGen` and `bcd`.

Parameters:
- NUM_CH, 4, number of requester channels (1..8).
- NUM_W, 16, binary width of each channel value and of the `bcd` number input.
- TIMEOUT, 64, maximum cycles waited in any single handshake phase before the channel is aborted.
- CH_W, clog2(NUM_CH) (min 1), channel index width (derived, not overridable).

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- vsync  in  1  active-low vertical sync from `VgaSyncGen`.
- ch_enable  in  NUM_CH  per-channel participate mask, sampled at frame start.
- numbers  in  NUM_CH*NUM_W  channel values, ch0 in the LSBs.
- bcd_load  out  1  one-cycle start pulse to the converter.
- bcd_number  out  NUM_W  value being converted.
- bcd_ready  in  1  converter idle / result-valid level.
- bcd_digits  in  16  {dig_4, dig_3, dig_2, dig_1} from the converter.
- digits_out  out  NUM_CH*16  latched BCD per channel, ch0 in the LSBs.
- digits_valid  out  NUM_CH  channel holds a good result from the most recent conversion.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when the frame sweep ends.
- overrun  out  1  one-cycle pulse when a frame edge arrives while busy.
- timeout_err  out  NUM_CH  sticky per-channel timeout flags.

Behaviour:
- Reset (synchronous):
  - state=IDLE, vsync_q=0.
  - bcd_load=0, bcd_number=0, digits_out=0, digits_valid=0.
  - busy=0, done=0, overrun=0, timeout_err=0.
  - Reset mid-sweep aborts at once; the converter's own reset is separate.
- frame_start = vsync_q & ~vsync, where vsync_q is registered every cycle.
- frame_start while busy: ignored, overrun=1 for that cycle, sweep continues.
- IDLE:
  - On frame_start, snapshot numbers into snap[] and ch_enable into en_q.
  - If en_q==0 (all channels disabled): pulse done next cycle, stay IDLE.
  - Otherwise set ch=lowest enabled index and go to LOAD (entered cycle T+1).
- LOAD (1 cycle):
  - bcd_load=1, bcd_number=snap[ch]; clear timer; go to WAIT_ACK.
  - bcd_number holds snap[ch] until the channel completes.
- WAIT_ACK:
  - bcd_ready==0 -> WAIT_DONE, clear timer.
  - Else if timer==TIMEOUT-1 -> ABORT.
  - Else timer++.
- WAIT_DONE:
  - bcd_ready==1 -> digits_out[ch]<=bcd_digits, digits_valid[ch]<=1, go to NEXT.
  - Else if timer==TIMEOUT-1 -> ABORT.
  - Else timer++.
- ABORT (1 cycle): digits_valid[ch]<=0, timeout_err[ch]<=1, go to NEXT.
- NEXT (1 cycle):
  - Go to the next enabled index above ch -> LOAD.
  - If none remain -> IDLE with done=1 on the transition cycle.
  - No wrap-around: ch0 is never revisited in the same sweep.
- digits_out[ch] keeps its last good value on abort; only digits_valid clears.
- Disabled channels keep their digits_out and digits_valid untouched.
- timeout_err clears only on reset.
- Sweep latency per channel: LOAD(1) + WAIT_ACK(>=1) + WAIT_DONE(conversion) + NEXT(1).
- busy is a registered decode of state != IDLE.
- done and overrun are registered single-cycle pulses.

Decomposition:
- Shared package `bcd_sched_pkg`:
  - state encoding IDLE/LOAD/WAIT_ACK/WAIT_DONE/ABORT/NEXT;
  - DIGITS_W=16;
  - default TIMEOUT.
- Sub-module `next_channel_finder`: combinational priority encoder.
  - Inputs: en_q and current ch.
  - Outputs: next enabled index above ch, plus a `found` bit.
  - Also used with ch=-1 (all-ones start flag) to pick the first channel.

Test Plan:
- Convert all channels: NUM_CH=4, numbers={9999,0,42,1234}, all enabled, behavioural bcd model (ready low 20 cycles after load), one vsync falling edge.
  - Expect digits_out={0x9999,0x0000,0x0042,0x1234} and digits_valid=4'hF.
  - Expect exactly 4 bcd_load pulses, ch0 first, then done pulse.
- Mask and snapshot: ch_enable=4'b0101, numbers change mid-sweep.
  - Only ch0 and ch2 are converted, using the frame-start snapshot values; ch1 and ch3 are untouched.
  - ch_enable=0 -> done one cycle after the edge, zero loads.
- Overrun: second vsync falling edge issued while busy -> overrun pulses once; sweep completes normally; no extra loads.
- Timeout: model never drops ready for ch1.
  - Expect ABORT after TIMEOUT cycles, timeout_err=4'b0010, digits_valid[1]=0, and ch2/ch3 still converted.
- Reset mid-sweep: assert reset during WAIT_DONE of ch2.
  - Next cycle: all outputs at reset values, state IDLE.
  - The following frame edge runs a clean sweep.
